// File: rtl/matmul_addr_gen_if.sv
// -----------------------------------------------------------------------------
// matmul_addr_gen_if
// Operand-address stream between the matmul loop sequencer and the MAC
// datapath. One triple moves per cycle in which op_valid and op_ready are
// both high.
//   op_valid   : triple on op_addr_* is valid
//   op_ready   : consumer accepts the triple
//   op_addr_a  : byte address of A[i][k]
//   op_addr_b  : byte address of B[k][j]
//   op_addr_c  : byte address of C[i][j]
//   op_first   : k == 0, consumer clears its accumulator
//   op_last    : k == K-1, consumer writes C[i][j]
// Modports: master (address generator), slave (MAC datapath).
// -----------------------------------------------------------------------------
interface matmul_addr_gen_if;
   logic        op_valid;
   logic        op_ready;
   logic [31:0] op_addr_a;
   logic [31:0] op_addr_b;
   logic [31:0] op_addr_c;
   logic        op_first;
   logic        op_last;

   modport master (
      output op_valid, op_addr_a, op_addr_b, op_addr_c, op_first, op_last,
      input  op_ready
   );

   modport slave (
      input  op_valid, op_addr_a, op_addr_b, op_addr_c, op_first, op_last,
      output op_ready
   );
endinterface

// File: rtl/matmul_addr_gen.sv
// -----------------------------------------------------------------------------
// matmul_addr_gen
// Registered loop sequencer upstream of the matmul MAC datapath. Reads the
// A and B headers (rows at base, cols at base+4), checks that A.cols equals
// B.rows and that every dimension is non-zero and fits in DIM_W bits, writes
// the C header, then walks i (outer) / j (middle) / k (inner) and issues one
// operand-address triple per stream transfer.
//
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   start               : run request, honoured only in IDLE
//   addr_a/b/c          : header base addresses, captured on accepted start
//   hdr_addr / hdr_data : header read port (combinational-read memory)
//   c_hdr_we/addr/wd    : C header write port
//   op                  : operand stream (matmul_addr_gen_if.master)
//   busy                : high in every state except IDLE
//   done                : one-cycle pulse at end of run (success or error)
//   err_dim             : sticky dimension error, cleared by accepted start
//   stall_cnt           : only with MATMUL_ADDRGEN_STALL_CNT_EN defined;
//                         saturating count of stalled ISSUE cycles
//
// Optional feature macro: MATMUL_ADDRGEN_STALL_CNT_EN
// Assumes DIM_W < 32.
// -----------------------------------------------------------------------------
module matmul_addr_gen #(
   parameter int DIM_W      = 16,
   parameter int ELEM_BYTES = 4,
   parameter int HDR_BYTES  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [31:0]            addr_a,
   input  logic [31:0]            addr_b,
   input  logic [31:0]            addr_c,
   output logic [31:0]            hdr_addr,
   input  logic [31:0]            hdr_data,
   output logic                   c_hdr_we,
   output logic [31:0]            c_hdr_addr,
   output logic [31:0]            c_hdr_wd,
   matmul_addr_gen_if.master      op,
   output logic                   busy,
   output logic                   done,
   output logic                   err_dim
`ifdef MATMUL_ADDRGEN_STALL_CNT_EN
   ,
   output logic [31:0]            stall_cnt
`endif
);

   typedef enum logic [3:0] {
      IDLE, RD_AR, RD_AC, RD_BR, RD_BC, CHECK, WR_CR, WR_CC, ISSUE, DONE
   } state_t;

   localparam logic [31:0]      EB  = 32'(ELEM_BYTES);
   localparam logic [31:0]      HB  = 32'(HDR_BYTES);
   localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

   state_t state, state_nxt;

   logic [31:0]      base_a, base_b, base_c;
   logic [DIM_W-1:0] ar, ac, br, bc;
   logic             dim_big;
   logic [DIM_W-1:0] i, j, k;
   // Running pointers replace the i*AC+k style multiplies.
   logic [31:0]      ptr_a, ptr_b, ptr_c;
   logic [31:0]      a_row;   // address of A[i][0]
   logic [31:0]      b_col;   // address of B[0][j]

   logic too_big, dim_err, issue, fire, k_end, j_end, last_op;
   logic [31:0] stride_b;

   assign too_big  = |hdr_data[31:DIM_W];
   assign dim_err  = dim_big || (ac != br) ||
                     (ar == '0) || (ac == '0) || (br == '0) || (bc == '0);
   assign issue    = (state == ISSUE);
   assign fire     = issue && op.op_ready;
   assign k_end    = (k == ac - ONE);
   assign j_end    = (j == bc - ONE);
   assign last_op  = k_end && j_end && (i == ar - ONE);
   assign stride_b = EB * 32'(bc);   // one step in k moves B down one row

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RD_AR;
         RD_AR:   state_nxt = RD_AC;
         RD_AC:   state_nxt = RD_BR;
         RD_BR:   state_nxt = RD_BC;
         RD_BC:   state_nxt = CHECK;
         CHECK:   state_nxt = dim_err ? DONE : WR_CR;
         WR_CR:   state_nxt = WR_CC;
         WR_CC:   state_nxt = ISSUE;
         ISSUE:   if (fire && last_op) state_nxt = DONE;
         DONE:    state_nxt = IDLE;   // start in DONE is deliberately dropped
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      hdr_addr   = '0;
      c_hdr_we   = 1'b0;
      c_hdr_addr = '0;
      c_hdr_wd   = '0;
      case (state)
         RD_AR: hdr_addr = base_a;
         RD_AC: hdr_addr = base_a + 32'd4;
         RD_BR: hdr_addr = base_b;
         RD_BC: hdr_addr = base_b + 32'd4;
         WR_CR: begin
            c_hdr_we   = 1'b1;
            c_hdr_addr = base_c;
            c_hdr_wd   = 32'(ar);
         end
         WR_CC: begin
            c_hdr_we   = 1'b1;
            c_hdr_addr = base_c + 32'd4;
            c_hdr_wd   = 32'(bc);
         end
         default: ;
      endcase
      busy         = (state != IDLE);
      done         = (state == DONE);
      op.op_valid  = issue;
      op.op_first  = issue && (k == '0);
      op.op_last   = issue && k_end;
      op.op_addr_a = ptr_a;
      op.op_addr_b = ptr_b;
      op.op_addr_c = ptr_c;
   end

   // Datapath: captured bases, header values, loop counters, pointers.
   // Pointers only move on a transfer, which keeps op_* stable during stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_a  <= '0;  base_b <= '0;  base_c <= '0;
         ar      <= '0;  ac     <= '0;  br     <= '0;  bc <= '0;
         dim_big <= 1'b0;
         err_dim <= 1'b0;
         i       <= '0;  j      <= '0;  k      <= '0;
         ptr_a   <= '0;  ptr_b  <= '0;  ptr_c  <= '0;
         a_row   <= '0;  b_col  <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               base_a  <= addr_a;
               base_b  <= addr_b;
               base_c  <= addr_c;
               err_dim <= 1'b0;
            end
            RD_AR: begin ar <= hdr_data[DIM_W-1:0]; dim_big <= too_big;           end
            RD_AC: begin ac <= hdr_data[DIM_W-1:0]; dim_big <= dim_big | too_big; end
            RD_BR: begin br <= hdr_data[DIM_W-1:0]; dim_big <= dim_big | too_big; end
            RD_BC: begin bc <= hdr_data[DIM_W-1:0]; dim_big <= dim_big | too_big; end
            CHECK: if (dim_err) err_dim <= 1'b1;
            WR_CC: begin
               i     <= '0;  j <= '0;  k <= '0;
               ptr_a <= base_a + HB;
               a_row <= base_a + HB;
               ptr_b <= base_b + HB;
               b_col <= base_b + HB;
               ptr_c <= base_c + HB;
            end
            ISSUE: if (fire) begin
               if (!k_end) begin
                  k     <= k + ONE;
                  ptr_a <= ptr_a + EB;
                  ptr_b <= ptr_b + stride_b;
               end else begin
                  k     <= '0;
                  ptr_c <= ptr_c + EB;   // C is visited in storage order
                  if (!j_end) begin
                     j     <= j + ONE;
                     ptr_a <= a_row;     // replay the same A row
                     ptr_b <= b_col + EB;
                     b_col <= b_col + EB;
                  end else begin
                     // Next A row starts right after the current one ends.
                     j     <= '0;
                     i     <= i + ONE;
                     ptr_a <= ptr_a + EB;
                     a_row <= ptr_a + EB;
                     ptr_b <= base_b + HB;
                     b_col <= base_b + HB;
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MATMUL_ADDRGEN_STALL_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (state == IDLE && start) begin
         stall_cnt <= '0;
      end else if (issue && !op.op_ready && stall_cnt != 32'hFFFF_FFFF) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_matmul_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_matmul_addr_gen
// Self-checking bench for matmul_addr_gen. A header memory model answers
// header reads; expected operand triples are produced by plain nested loops
// over the address formulas. Inputs change 1 ns after the rising edge and
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_matmul_addr_gen;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        first;
      logic        last;
   } op_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   localparam int HDR_BYTES  = 8;
   localparam int ELEM_BYTES = 4;
   localparam int BUDGET     = 3000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] addr_a = '0, addr_b = '0, addr_c = '0;
   logic [31:0] hdr_addr, hdr_data, c_hdr_addr, c_hdr_wd;
   logic        c_hdr_we, busy, done, err_dim;
`ifdef MATMUL_ADDRGEN_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   matmul_addr_gen_if op ();

   matmul_addr_gen dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .addr_a     (addr_a),
      .addr_b     (addr_b),
      .addr_c     (addr_c),
      .hdr_addr   (hdr_addr),
      .hdr_data   (hdr_data),
      .c_hdr_we   (c_hdr_we),
      .c_hdr_addr (c_hdr_addr),
      .c_hdr_wd   (c_hdr_wd),
      .op         (op),
      .busy       (busy),
      .done       (done),
      .err_dim    (err_dim)
`ifdef MATMUL_ADDRGEN_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Header memory: only the four header words of the current job exist.
   logic [31:0] m_ba = '0, m_bb = '0;
   logic [31:0] m_ar = '0, m_ac = '0, m_br = '0, m_bc = '0;
   always_comb begin
      if      (hdr_addr == m_ba)          hdr_data = m_ar;
      else if (hdr_addr == m_ba + 32'd4)  hdr_data = m_ac;
      else if (hdr_addr == m_bb)          hdr_data = m_br;
      else if (hdr_addr == m_bb + 32'd4)  hdr_data = m_bc;
      else                                hdr_data = 32'hDEAD_BEEF;
   end

   int checks = 0;
   int errors = 0;

   // Observations of the last job
   op_t obs_q[$];
   op_t exp_q[$];
   wr_t wr_q[$];
   int  done_cnt, done_cyc, first_valid, stall_viol, stall_cycles;
   bit  timed_out;
   logic busy_after, err_after, done_after, err_c1;

   function automatic logic ready_of(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 3) == 0;
         default: return $urandom_range(0, 3) != 0;
      endcase
   endfunction

   // Reference: i outer, j middle, k inner, addresses straight from formulas.
   function automatic void build_model(input logic [31:0] ba, bb, bcb,
                                       input int ar, ac, bc);
      exp_q.delete();
      for (int i = 0; i < ar; i++)
         for (int j = 0; j < bc; j++)
            for (int k = 0; k < ac; k++) begin
               op_t t;
               t.a     = ba  + 32'(HDR_BYTES + ELEM_BYTES * (i * ac + k));
               t.b     = bb  + 32'(HDR_BYTES + ELEM_BYTES * (k * bc + j));
               t.c     = bcb + 32'(HDR_BYTES + ELEM_BYTES * (i * bc + j));
               t.first = (k == 0);
               t.last  = (k == ac - 1);
               exp_q.push_back(t);
            end
   endfunction

   // Index of first difference between observed and expected triples:
   // -1 when identical, -2 when lengths differ.
   function automatic int first_diff();
      if (obs_q.size() != exp_q.size()) return -2;
      foreach (exp_q[n]) if (obs_q[n] !== exp_q[n]) return n;
      return -1;
   endfunction

   // Runs one job from the start pulse to the done pulse (or budget).
   // Entered and left 1 ns after a rising edge. inject_at: cycle index at
   // which a second start with foreign bases is pulsed (-1 for none).
   task automatic run_job(input logic [31:0] ba, bb, bcb,
                          input logic [31:0] ar, ac, br, bc,
                          input int mode, input int inject_at);
      logic prev_stall;
      op_t  prev_op, cur;
      int   cyc;
      obs_q.delete(); wr_q.delete();
      done_cnt = 0; done_cyc = -1; first_valid = -1;
      stall_viol = 0; stall_cycles = 0; timed_out = 1'b0; err_c1 = 1'bx;
      prev_stall = 1'b0; prev_op = '0;
      m_ba = ba; m_bb = bb; m_ar = ar; m_ac = ac; m_br = br; m_bc = bc;
      addr_a = ba; addr_b = bb; addr_c = bcb;
      start = 1'b1;
      op.op_ready = ready_of(mode, 0);
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      op.op_ready = ready_of(mode, cyc);
      forever begin
         @(negedge clk);
         cur = {op.op_addr_a, op.op_addr_b, op.op_addr_c, op.op_first, op.op_last};
         if (cyc == 1) err_c1 = err_dim;
         if (c_hdr_we) wr_q.push_back({c_hdr_addr, c_hdr_wd});
         if (op.op_valid && first_valid < 0) first_valid = cyc;
         if (prev_stall && (!op.op_valid || cur !== prev_op)) stall_viol++;
         prev_stall = op.op_valid && !op.op_ready;
         prev_op    = cur;
         if (prev_stall) stall_cycles++;
         if (op.op_valid && op.op_ready) obs_q.push_back(cur);
         if (done) begin done_cnt++; done_cyc = cyc; end
         @(posedge clk); #1;
         if (done_cyc >= 0) break;
         cyc++;
         if (cyc > BUDGET) begin timed_out = 1'b1; break; end
         op.op_ready = ready_of(mode, cyc);
         start = (cyc == inject_at);
         if (start) begin
            addr_a = 32'h0000_7000; addr_b = 32'h0000_8000; addr_c = 32'h0000_9000;
         end
      end
      start = 1'b0;
      @(negedge clk);
      busy_after = busy; err_after = err_dim; done_after = done;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if ({busy, done, err_dim, c_hdr_we, op.op_valid, op.op_first, op.op_last} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got busy=%b done=%b err=%b we=%b valid=%b first=%b last=%b, want all 0",
                  busy, done, err_dim, c_hdr_we, op.op_valid, op.op_first, op.op_last);
      end
      checks++;
      if ({hdr_addr, c_hdr_addr, c_hdr_wd} !== 96'b0) begin
         errors++;
         $display("FAIL reset_hdr_bus: got hdr_addr=%h c_hdr_addr=%h c_hdr_wd=%h, want 0",
                  hdr_addr, c_hdr_addr, c_hdr_wd);
      end
      checks++;
      if ({op.op_addr_a, op.op_addr_b, op.op_addr_c} !== 96'b0) begin
         errors++;
         $display("FAIL reset_op_addr: got %h %h %h, want 0",
                  op.op_addr_a, op.op_addr_b, op.op_addr_c);
      end
`ifdef MATMUL_ADDRGEN_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_stall_cnt: got %0d, want 0", stall_cnt);
      end
`endif
      op.op_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_nominal();
      int d;
      run_job(32'h100, 32'h200, 32'h300, 2, 3, 3, 2, 0, -1);
      build_model(32'h100, 32'h200, 32'h300, 2, 3, 2);
      checks++;
      if (timed_out !== 1'b0) begin
         errors++; $display("FAIL nominal_timeout: got no done within %0d cycles", BUDGET);
      end
      checks++;
      if (first_valid !== 8) begin
         errors++; $display("FAIL nominal_latency: got op_valid in cycle %0d, want 8", first_valid);
      end
      checks++;
      if (wr_q.size() !== 2 || wr_q[0] !== {32'h300, 32'd2} || wr_q[1] !== {32'h304, 32'd2}) begin
         errors++;
         $display("FAIL nominal_c_hdr: got %0d writes (first %h), want 0x300<-2, 0x304<-2",
                  wr_q.size(), wr_q.size() > 0 ? wr_q[0] : 64'h0);
      end
      checks++;
      d = first_diff();
      if (d != -1) begin
         errors++;
         $display("FAIL nominal_seq: got %0d transfers, want %0d, first diff index %0d",
                  obs_q.size(), exp_q.size(), d);
      end
      checks++;
      if (obs_q.size() !== 12 || obs_q[0] !== {32'h108, 32'h208, 32'h308, 1'b1, 1'b0} ||
          obs_q[11] !== {32'h11C, 32'h21C, 32'h314, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL nominal_ends: got size %0d first %h last %h, want 12 transfers 108/208/308 .. 11C/21C/314",
                  obs_q.size(), obs_q.size() > 0 ? obs_q[0] : '0,
                  obs_q.size() > 0 ? obs_q[obs_q.size() - 1] : '0);
      end
      checks++;
      if ({done_cnt == 1, busy_after, err_after, done_after} !== 4'b1000) begin
         errors++;
         $display("FAIL nominal_end_state: got done_cnt=%0d busy=%b err=%b done_after=%b, want 1/0/0/0",
                  done_cnt, busy_after, err_after, done_after);
      end
   endtask

   task automatic test_dim_errors();
      logic [31:0] tab [3][4];
      tab[0] = '{32'd2, 32'd3, 32'd2, 32'd2};      // AC != BR
      tab[1] = '{32'd2, 32'd0, 32'd0, 32'd2};      // zero inner dimension
      tab[2] = '{32'h1_0000, 32'd1, 32'd1, 32'd1}; // row count beyond 16 bits
      for (int n = 0; n < 3; n++) begin
         run_job(32'h400, 32'h500, 32'h600, tab[n][0], tab[n][1], tab[n][2], tab[n][3], 0, -1);
         checks++;
         if (timed_out || done_cyc !== 6 || err_after !== 1'b1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL dim_err_%0d: got done cycle %0d err=%b done_cnt=%0d, want cycle 6 err=1 one pulse",
                     n, done_cyc, err_after, done_cnt);
         end
         checks++;
         if (wr_q.size() !== 0 || first_valid !== -1 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL dim_err_side_%0d: got %0d header writes, valid cycle %0d, busy=%b, want 0/-1/0",
                     n, wr_q.size(), first_valid, busy_after);
         end
      end
      // Error flag must drop on the next accepted start.
      run_job(32'h100, 32'h200, 32'h300, 2, 3, 3, 2, 0, -1);
      checks++;
      if (err_c1 !== 1'b0 || err_after !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: got err_dim=%b after start, %b after run, want 0/0", err_c1, err_after);
      end
   endtask

   task automatic test_backpressure();
      int d;
      run_job(32'h100, 32'h200, 32'h300, 2, 3, 3, 2, 1, -1);
      build_model(32'h100, 32'h200, 32'h300, 2, 3, 2);
      checks++;
      d = first_diff();
      if (timed_out || d != -1) begin
         errors++;
         $display("FAIL bp_seq: got %0d transfers, want %0d, first diff index %0d",
                  obs_q.size(), exp_q.size(), d);
      end
      checks++;
      if (stall_viol !== 0 || stall_cycles == 0) begin
         errors++;
         $display("FAIL bp_stable: got %0d unstable stall cycles of %0d, want 0 of >0",
                  stall_viol, stall_cycles);
      end
`ifdef MATMUL_ADDRGEN_STALL_CNT_EN
      checks++;
      if (stall_cnt !== 32'(stall_cycles)) begin
         errors++;
         $display("FAIL bp_stall_cnt: got %0d, want %0d", stall_cnt, stall_cycles);
      end
`endif
   endtask

   task automatic test_smallest();
      run_job(32'h20, 32'h40, 32'h60, 1, 1, 1, 1, 0, -1);
      checks++;
      if (timed_out || obs_q.size() !== 1 || done_cnt !== 1) begin
         errors++;
         $display("FAIL small_count: got %0d transfers, %0d done pulses, want 1/1", obs_q.size(), done_cnt);
      end
      checks++;
      if (obs_q.size() < 1 || obs_q[0] !== {32'h28, 32'h48, 32'h68, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL small_op: got %h, want 28/48/68 first=1 last=1",
                  obs_q.size() > 0 ? obs_q[0] : '0);
      end
   endtask

   task automatic test_reset_midrun();
      int n, seen, d;
      m_ba = 32'h100; m_bb = 32'h200; m_ar = 2; m_ac = 3; m_br = 3; m_bc = 2;
      addr_a = 32'h100; addr_b = 32'h200; addr_c = 32'h300;
      op.op_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!op.op_valid && n < 50) begin @(posedge clk); #1; n++; end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (op.op_valid !== 1'b1) begin
         errors++; $display("FAIL midrun_issue: got op_valid=%b before reset, want 1", op.op_valid);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({op.op_valid, busy, done, c_hdr_we} !== 4'b0) begin
         errors++;
         $display("FAIL midrun_async: got valid=%b busy=%b done=%b we=%b, want 0",
                  op.op_valid, busy, done, c_hdr_we);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (op.op_valid || c_hdr_we || busy) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL midrun_quiet: got %0d active cycles after reset, want 0", seen);
      end
      @(posedge clk); #1;
      run_job(32'h100, 32'h200, 32'h300, 2, 3, 3, 2, 0, -1);
      build_model(32'h100, 32'h200, 32'h300, 2, 3, 2);
      checks++;
      d = first_diff();
      if (timed_out || d != -1) begin
         errors++;
         $display("FAIL midrun_rerun: got %0d transfers, want %0d, first diff index %0d",
                  obs_q.size(), exp_q.size(), d);
      end
   endtask

   task automatic test_start_busy();
      int d;
      int at [2];
      at = '{12, 20};   // mid-ISSUE, and the DONE cycle of a stall-free run
      for (int n = 0; n < 2; n++) begin
         run_job(32'h100, 32'h200, 32'h300, 2, 3, 3, 2, 0, at[n]);
         build_model(32'h100, 32'h200, 32'h300, 2, 3, 2);
         checks++;
         d = first_diff();
         if (timed_out || d != -1 || done_cyc !== 20) begin
            errors++;
            $display("FAIL busy_start_seq_%0d: got %0d transfers, first diff %0d, done cycle %0d, want %0d/-1/20",
                     n, obs_q.size(), d, done_cyc, exp_q.size());
         end
         checks++;
         if (busy_after !== 1'b0) begin
            errors++; $display("FAIL busy_start_idle_%0d: got busy=%b after done, want 0", n, busy_after);
         end
      end
   endtask

   task automatic test_random();
      int d, ar, ac, bc;
      logic [31:0] ba, bb, bcb;
      for (int n = 0; n < 8; n++) begin
         ar = $urandom_range(1, 4); ac = $urandom_range(1, 4); bc = $urandom_range(1, 4);
         ba  = {4'h1, 28'($urandom)};
         bb  = {4'h2, 28'($urandom)};
         bcb = {4'hF, 28'($urandom)};   // high base lets C addresses wrap
         run_job(ba, bb, bcb, 32'(ar), 32'(ac), 32'(ac), 32'(bc), 2, -1);
         build_model(ba, bb, bcb, ar, ac, bc);
         checks++;
         d = first_diff();
         if (timed_out || d != -1 || stall_viol != 0) begin
            errors++;
            $display("FAIL random_%0d (%0dx%0d x %0dx%0d): got %0d transfers, want %0d, first diff %0d, unstable stalls %0d",
                     n, ar, ac, ac, bc, obs_q.size(), exp_q.size(), d, stall_viol);
         end
         checks++;
         if (wr_q.size() !== 2 || wr_q[0] !== {bcb, 32'(ar)} || wr_q[1] !== {bcb + 32'd4, 32'(bc)}) begin
            errors++;
            $display("FAIL random_hdr_%0d: got %0d header writes, want 2 to %h", n, wr_q.size(), bcb);
         end
      end
   endtask

   initial begin
      op.op_ready = 1'b0;
      test_reset();
      test_nominal();
      test_dim_errors();
      test_backpressure();
      test_smallest();
      test_reset_midrun();
      test_start_busy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/matmul_addr_gen.md
Name: matmul_addr_gen

Overview:
- Registered loop sequencer that sits directly upstream of the matmul MAC datapath.
- Reads the A and B headers (rows at base, cols at base+4) from vector memory.
- Checks dimension compatibility and writes the C header.
- Walks i/j/k and issues one operand-address triple per handshake: A[i][k], B[k][j], C[i][j].
- Replaces the combinational index feedback with a clean FSM and valid/ready stream.

Parameters:
- DIM_W, 16: width of the i/j/k counters and stored dimensions. A header value >= 2^DIM_W is an error.
- ELEM_BYTES, 4: byte stride between consecutive matrix elements.
- HDR_BYTES, 8: byte offset from a matrix base address to its first element.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request. Sampled only in IDLE.
- addr_a  in  32  base address of A header. Sampled at start.
- addr_b  in  32  base address of B header. Sampled at start.
- addr_c  in  32  base address of C header. Sampled at start.
- hdr_addr  out  32  header read address (combinational-read memory)
- hdr_data  in  32  header read data for hdr_addr, same cycle
- c_hdr_we  out  1  C header write strobe
- c_hdr_addr  out  32  C header write address
- c_hdr_wd  out  32  C header write data
- op_valid  out  1  operand triple valid
- op_ready  in  1  downstream accepts the triple
- op_addr_a  out  32  address of A[i][k]
- op_addr_b  out  32  address of B[k][j]
- op_addr_c  out  32  address of C[i][j]
- op_first  out  1  k==0 (downstream clears its accumulator)
- op_last  out  1  k==K-1 (downstream writes C[i][j])
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a run (success or error)
- err_dim  out  1  sticky error flag. Cleared by the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE and all outputs 0. Captured bases, dimensions and counters are set to 0.
- Reset mid-run aborts immediately. No further op or header write occurs.
- States and transitions:
  - IDLE -> RD_AR on start. Latch the three bases and clear err_dim.
  - RD_AR -> RD_AC -> RD_BR -> RD_BC: one cycle each. hdr_addr = addr_a, addr_a+4, addr_b, addr_b+4 respectively. hdr_data is latched at the end of each cycle as AR, AC, BR, BC.
  - CHECK:
    - Error if AC != BR, if any dimension is 0, or if any dimension is >= 2^DIM_W. On error: err_dim=1, go to DONE.
    - Otherwise go to WR_CR.
  - WR_CR: c_hdr_we=1, c_hdr_addr=addr_c, c_hdr_wd=AR.
  - WR_CC: c_hdr_we=1, c_hdr_addr=addr_c+4, c_hdr_wd=BC. Then i=j=k=0 and go to ISSUE.
  - ISSUE: op_valid=1. Leave on the transfer of the final triple.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: start sampled at edge 0 gives op_valid high in the 8th cycle after that edge.
- Loop order: i outer (0..AR-1), j middle (0..BC-1), k inner (0..AC-1). One step per transfer (op_valid & op_ready).
- Address formulas (mod 2^32):
  - op_addr_a = addr_a + HDR_BYTES + ELEM_BYTES*(i*AC + k)
  - op_addr_b = addr_b + HDR_BYTES + ELEM_BYTES*(k*BC + j)
  - op_addr_c = addr_c + HDR_BYTES + ELEM_BYTES*(i*BC + j)
- Address generation may use running pointers instead of multipliers. Results must match the formulas exactly.
- Stall rule: while op_valid & !op_ready, all op_* outputs are held stable. op_valid never drops before the transfer.
- Wrap rules:
  - k wraps at AC-1 and j increments.
  - j wraps at BC-1 and i increments.
  - A transfer at i=AR-1, j=BC-1, k=AC-1 ends ISSUE and goes to DONE.
- Total transfers = AR*BC*AC.
- start outside IDLE is ignored. start coincident with DONE is also ignored.
- c_hdr_we is only ever high in WR_CR and WR_CC. It is never high on an error run.

Optional Feature:
- Macro: MATMUL_ADDRGEN_STALL_CNT_EN.
- Defined: adds output stall_cnt (32 bits).
  - Counts ISSUE cycles with op_valid & !op_ready.
  - Cleared to 0 on reset and on accepted start.
  - Saturates at 0xFFFFFFFF and holds its value after DONE.
- Undefined: port absent, no counter logic.

Test Plan:
- Nominal run:
  - Stimulus: A=2x3 at 0x100, B=3x2 at 0x200, C at 0x300, op_ready=1.
  - Response: header writes 0x300<-2 then 0x304<-2. 12 transfers.
  - First transfer: 0x108/0x208/0x308 with op_first=1.
  - Last transfer: 0x11C/0x21C/0x314 with op_last=1.
  - Then a done pulse, busy=0, err_dim=0.
- Dimension mismatch:
  - Stimulus: A=2x3, B=2x2.
  - Response: err_dim=1, done pulse in the 6th cycle after start. No c_hdr_we, no op_valid.
  - err_dim clears on the next start.
- Backpressure:
  - Stimulus: nominal run with op_ready toggling 1,0,0,1,...
  - Response: op_* stable during every stall. The address sequence is identical to the nominal run.
  - With MATMUL_ADDRGEN_STALL_CNT_EN defined, stall_cnt equals the number of stalled cycles.
- Smallest case:
  - Stimulus: 1x1 x 1x1.
  - Response: exactly one transfer with op_first=op_last=1, then done.
- Reset mid-run:
  - Stimulus: assert reset during ISSUE with op_valid high.
  - Response: op_valid=0, busy=0 and state=IDLE immediately (asynchronous).
  - A fresh start after release reproduces the nominal sequence.
- Start while busy:
  - Stimulus: pulse start during ISSUE with different bases.
  - Response: ignored. The sequence and addresses of the current run are unchanged.
